ascii_write_scheduler: RTL and testbench
========================================

Name: ascii_write_scheduler

Overview:
Shares the text-buffer write port between two ASCII character sources: the test character generator (gen) and the keyboard path (kbd). Writes are paced by a programmable tick; both sources are arbitrated round-robin. Accepted characters are written to sequential buffer addresses. The block also sequences a buffer clear (fills every location with space, 0x20). It sits between the character sources and the text-buffer/VGA text RAM.

Parameters:
TICK_DIV, 1000000, clock cycles between write opportunities (≥1)
BUF_DEPTH, 2048, character locations in the text buffer (≤2^ADDR_W)
ADDR_W, 11, buffer address width

Ports:
clk  input  1  system clock
reset_n  input  1  reset; synchronous, active-low
execute  input  1  enable; when low no new grants are issued
clear  input  1  request to clear the buffer (level or pulse, sampled per Behaviour)
gen_valid  input  1  generator has a character
gen_char  input  8  generator character
gen_ready  output  1  one-cycle accept strobe to generator
kbd_valid  input  1  keyboard has a character
kbd_char  input  8  keyboard character
kbd_ready  output  1  one-cycle accept strobe to keyboard
wr_en  output  1  buffer write strobe
wr_addr  output  ADDR_W  buffer write address
wr_data  output  8  buffer write data
char_count  output  ADDR_W+1  characters written since reset/clear
full  output  1  char_count == BUF_DEPTH
busy  output  1  clear sequence in progress

Behaviour:
- All outputs are registered. Reset values: wr_en=0, wr_addr=0, wr_data=0, char_count=0, full=0, busy=0, gen_ready=0, kbd_ready=0. Internal state: last_src=kbd (gen wins the first tie), tick counter=0, state=S_IDLE, clear_pending=0.
- Tick counter: free-running 0..TICK_DIV-1, then wraps to 0. tick=1 for the single cycle where the count is TICK_DIV-1. With TICK_DIV=1, tick is high every cycle. Ticks arriving outside S_IDLE are dropped, not queued.
- States: S_IDLE, S_GRANT, S_WRITE, S_CLEAR.
- S_IDLE, priority order:
  - clear or clear_pending set → enter S_CLEAR; clear_pending is cleared.
  - Otherwise, tick & execute & !full & (gen_valid|kbd_valid) → select a source and go to S_GRANT.
  - Selection: if only one source is valid, select it. If both are valid, select the one that is not last_src.
- S_GRANT (1 cycle):
  - The selected source's ready is high for exactly this cycle.
  - Character is captured, last_src is updated, go to S_WRITE.
  - Sources must hold valid and char stable from assertion until ready. Dropping valid early is a protocol violation with undefined data.
- S_WRITE (1 cycle):
  - wr_en=1, wr_addr=char_count[ADDR_W-1:0], wr_data=captured character.
  - char_count increments, registered on the same edge that clears wr_en.
  - full updates on that same edge. Return to S_IDLE.
- Latency: tick at cycle T → ready at T+1 → wr_en at T+2.
- execute falling during S_GRANT/S_WRITE: the in-flight transfer completes; no further grants.
- clear asserted during S_GRANT/S_WRITE: clear_pending is set; the clear is taken on return to S_IDLE.
- S_CLEAR:
  - busy=1, wr_en=1 every cycle, wr_data=0x20, wr_addr runs 0..BUF_DEPTH-1, one per cycle, not tick-paced.
  - After the last address: char_count=0, full=0, last_src=kbd, busy=0, wr_en=0, return to S_IDLE.
  - No ready is issued while busy.
- full: no grants while full; the write address never exceeds BUF_DEPTH-1; char_count saturates at BUF_DEPTH.
- reset_n low in any state, including mid-clear: the next clock edge restores all reset values. The clear is aborted, not resumed.

Test Plan:
- TICK_DIV=4, BUF_DEPTH=8, ADDR_W=3 unless noted. Release reset, execute=1, hold gen_valid=1 with gen_char=0x61 → tick when counter=3; gen_ready one cycle later; next cycle wr_en=1, wr_addr=0, wr_data=0x61; char_count=1.
- gen_valid and kbd_valid both held (gen 0x61, kbd 0x41) → grants alternate gen, kbd, gen… on successive ticks; writes addr0=0x61, addr1=0x41, addr2=0x61; exactly one ready per tick.
- Keep gen valid until 8 writes → full=1, char_count=8; further ticks produce no ready or wr_en; wr_addr never wraps to 0.
- Assert clear when full → busy=1 for 8 cycles; wr_en each cycle; addr 0..7; data 0x20. Then char_count=0, full=0; with both sources valid the next grant goes to gen.
- Drop execute the cycle after a tick, and assert clear on that same cycle → the pending ready/write still completes. The clear sequence starts on the cycle after return to S_IDLE. No grants follow while execute=0.
- TICK_DIV=1: gen valid continuously → a write every 3 cycles (idle, grant, write). Pull reset_n low at clear address 4 → next edge all outputs are at reset values; wr_en=0 and clear is not resumed.

Source files
------------

// File: rtl/ascii_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ascii_write_scheduler
// Brief    : Tick-paced round-robin writer of gen/kbd characters into a text
//            buffer, with a full-buffer clear-to-space sequence.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_write_scheduler #(
  parameter int TICK_DIV  = 1000000,
  parameter int BUF_DEPTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_execute,
  input  logic              i_clear,
  input  logic              i_gen_valid,
  input  logic [7:0]        i_gen_char,
  output logic              o_gen_ready,
  input  logic              i_kbd_valid,
  input  logic [7:0]        i_kbd_char,
  output logic              o_kbd_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W:0]   o_char_count,
  output logic              o_full,
  output logic              o_busy
);

  localparam int                c_CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_TICK_ONE  = c_CNT_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(BUF_DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W + 1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic              c_SRC_GEN   = 1'b0;
  localparam logic              c_SRC_KBD   = 1'b1;
  localparam logic [7:0]        c_SPACE     = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_tick_cnt;
  logic                w_tick;
  logic                r_last_src, w_last_src_nxt;
  logic                r_sel, w_sel_nxt;
  logic                r_clear_pending, w_clear_pending_nxt;
  logic                r_gen_ready, w_gen_ready_nxt;
  logic                r_kbd_ready, w_kbd_ready_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [7:0]          r_wr_data, w_wr_data_nxt;
  logic [ADDR_W:0]     r_char_count, w_char_count_nxt;
  logic [ADDR_W:0]     w_count_inc;
  logic                r_full, w_full_nxt;
  logic                r_busy, w_busy_nxt;

  // Free-running pacing counter; it keeps counting in every state so ticks
  // that land outside S_IDLE are simply lost.
  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
    end
  end

  assign w_count_inc = r_char_count + c_CNT_ONE;

  always_comb begin
    w_state_nxt         = r_state;
    w_last_src_nxt      = r_last_src;
    w_sel_nxt           = r_sel;
    w_clear_pending_nxt = r_clear_pending;
    w_gen_ready_nxt     = 1'b0;
    w_kbd_ready_nxt     = 1'b0;
    w_wr_en_nxt         = 1'b0;
    w_busy_nxt          = 1'b0;
    w_wr_addr_nxt       = r_wr_addr;
    w_wr_data_nxt       = r_wr_data;
    w_char_count_nxt    = r_char_count;
    w_full_nxt          = r_full;

    unique case (r_state)
      S_IDLE: begin
        if (i_clear || r_clear_pending) begin
          w_state_nxt         = S_CLEAR;
          w_clear_pending_nxt = 1'b0;
          w_busy_nxt          = 1'b1;
          w_wr_en_nxt         = 1'b1;
          w_wr_addr_nxt       = '0;
          w_wr_data_nxt       = c_SPACE;
        end else if (w_tick && i_execute && !r_full && (i_gen_valid || i_kbd_valid)) begin
          // On a tie the source that did not win last time gets the slot.
          if (i_gen_valid && (!i_kbd_valid || (r_last_src == c_SRC_KBD))) begin
            w_sel_nxt       = c_SRC_GEN;
            w_gen_ready_nxt = 1'b1;
          end else begin
            w_sel_nxt       = c_SRC_KBD;
            w_kbd_ready_nxt = 1'b1;
          end
          w_state_nxt = S_GRANT;
        end
      end

      S_GRANT: begin
        if (i_clear) begin
          w_clear_pending_nxt = 1'b1;
        end
        w_last_src_nxt = r_sel;
        w_wr_en_nxt    = 1'b1;
        w_wr_addr_nxt  = r_char_count[ADDR_W-1:0];
        w_wr_data_nxt  = (r_sel == c_SRC_GEN) ? i_gen_char : i_kbd_char;
        w_state_nxt    = S_WRITE;
      end

      S_WRITE: begin
        if (i_clear) begin
          w_clear_pending_nxt = 1'b1;
        end
        if (!r_full) begin
          w_char_count_nxt = w_count_inc;
          w_full_nxt       = (w_count_inc == c_DEPTH);
        end
        w_state_nxt = S_IDLE;
      end

      S_CLEAR: begin
        if (r_wr_addr == c_ADDR_LAST) begin
          w_char_count_nxt = '0;
          w_full_nxt       = 1'b0;
          w_last_src_nxt   = c_SRC_KBD;
          w_state_nxt      = S_IDLE;
        end else begin
          w_busy_nxt    = 1'b1;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_wr_addr + c_ADDR_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_state         <= S_IDLE;
      r_last_src      <= c_SRC_KBD;
      r_sel           <= c_SRC_GEN;
      r_clear_pending <= 1'b0;
      r_gen_ready     <= 1'b0;
      r_kbd_ready     <= 1'b0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_char_count    <= '0;
      r_full          <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_last_src      <= w_last_src_nxt;
      r_sel           <= w_sel_nxt;
      r_clear_pending <= w_clear_pending_nxt;
      r_gen_ready     <= w_gen_ready_nxt;
      r_kbd_ready     <= w_kbd_ready_nxt;
      r_wr_en         <= w_wr_en_nxt;
      r_wr_addr       <= w_wr_addr_nxt;
      r_wr_data       <= w_wr_data_nxt;
      r_char_count    <= w_char_count_nxt;
      r_full          <= w_full_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  assign o_gen_ready  = r_gen_ready;
  assign o_kbd_ready  = r_kbd_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_char_count = r_char_count;
  assign o_full       = r_full;
  assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ascii_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_write_scheduler
// Brief    : Two scheduler instances (TICK_DIV 4 and 1) against an
//            event-scheduled reference model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_write_scheduler;

  localparam int D  = 8;
  localparam int AW = 3;
  localparam int EV_NONE = 0, EV_WRITE = 1, EV_INC = 2, EV_CLRW = 3, EV_CLRDONE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, execute, clear, gen_valid, kbd_valid;
  logic [7:0] gen_char [2];
  logic [7:0] kbd_char [2];
  wire  [1:0] gen_ready, kbd_ready, wr_en, full, busy;
  wire  [AW-1:0] wr_addr [2];
  wire  [7:0]    wr_data [2];
  wire  [AW:0]   char_count [2];

  ascii_write_scheduler #(.TICK_DIV(4), .BUF_DEPTH(D), .ADDR_W(AW)) u_dut0 (
    .clk(clk), .i_reset_n(rst_n[0]), .i_execute(execute[0]), .i_clear(clear[0]),
    .i_gen_valid(gen_valid[0]), .i_gen_char(gen_char[0]), .o_gen_ready(gen_ready[0]),
    .i_kbd_valid(kbd_valid[0]), .i_kbd_char(kbd_char[0]), .o_kbd_ready(kbd_ready[0]),
    .o_wr_en(wr_en[0]), .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0]),
    .o_char_count(char_count[0]), .o_full(full[0]), .o_busy(busy[0]));

  ascii_write_scheduler #(.TICK_DIV(1), .BUF_DEPTH(D), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .i_reset_n(rst_n[1]), .i_execute(execute[1]), .i_clear(clear[1]),
    .i_gen_valid(gen_valid[1]), .i_gen_char(gen_char[1]), .o_gen_ready(gen_ready[1]),
    .i_kbd_valid(kbd_valid[1]), .i_kbd_char(kbd_char[1]), .o_kbd_ready(kbd_ready[1]),
    .o_wr_en(wr_en[1]), .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1]),
    .o_char_count(char_count[1]), .o_full(full[1]), .o_busy(busy[1]));

  // ---------------- bookkeeping ----------------
  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s[inst%0d] @%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  // Works on absolute edge numbers: a decision at edge t schedules every
  // future output change, and the model is idle again at edge m_free.
  int  m_t [2], m_free [2];
  bit  m_last_kbd [2], m_pend [2], m_clearing [2];
  bit  e_gr [2], e_kr [2], e_wen [2], e_busy [2], e_full [2];
  int  e_addr [2], e_data [2], e_count [2];
  int  ev_kind [2][16], ev_addr [2][16], ev_data [2][16];

  task automatic sched(input int k, input int at, input int kind, input int a, input int d);
    ev_kind[k][at % 16] = kind;
    ev_addr[k][at % 16] = a;
    ev_data[k][at % 16] = d;
  endtask

  task automatic model_edge(input int k);
    int  td, s, t;
    bit  take_gen;
    td = (k == 0) ? 4 : 1;
    t  = m_t[k];
    if (!rst_n[k]) begin
      m_t[k] = 0; m_free[k] = 0; m_last_kbd[k] = 1'b1; m_pend[k] = 1'b0; m_clearing[k] = 1'b0;
      e_gr[k] = 0; e_kr[k] = 0; e_wen[k] = 0; e_busy[k] = 0; e_full[k] = 0;
      e_addr[k] = 0; e_data[k] = 0; e_count[k] = 0;
      for (int i = 0; i < 16; i++) ev_kind[k][i] = EV_NONE;
    end else begin
      if (t < m_free[k] && !m_clearing[k] && clear[k]) m_pend[k] = 1'b1;
      e_gr[k] = 0; e_kr[k] = 0; e_wen[k] = 0; e_busy[k] = 0;
      s = t % 16;
      case (ev_kind[k][s])
        EV_WRITE:   begin e_wen[k] = 1; e_addr[k] = ev_addr[k][s]; e_data[k] = ev_data[k][s]; end
        EV_INC:     begin e_count[k] = e_count[k] + 1; e_full[k] = (e_count[k] == D); end
        EV_CLRW:    begin e_wen[k] = 1; e_busy[k] = 1; e_addr[k] = ev_addr[k][s]; e_data[k] = 8'h20; end
        EV_CLRDONE: begin e_count[k] = 0; e_full[k] = 0; m_last_kbd[k] = 1; m_clearing[k] = 0; end
        default: ;
      endcase
      ev_kind[k][s] = EV_NONE;
      if (t >= m_free[k]) begin
        if (clear[k] || m_pend[k]) begin
          m_pend[k] = 0; m_clearing[k] = 1;
          e_wen[k] = 1; e_busy[k] = 1; e_addr[k] = 0; e_data[k] = 8'h20;
          for (int i = 1; i < D; i++) sched(k, t + i, EV_CLRW, i, 0);
          sched(k, t + D, EV_CLRDONE, 0, 0);
          m_free[k] = t + D + 1;
        end else if ((t % td == td - 1) && execute[k] && !e_full[k] && (gen_valid[k] || kbd_valid[k])) begin
          take_gen = gen_valid[k] && (!kbd_valid[k] || m_last_kbd[k]);
          m_last_kbd[k] = !take_gen;
          if (take_gen) e_gr[k] = 1; else e_kr[k] = 1;
          sched(k, t + 1, EV_WRITE, e_count[k], take_gen ? int'(gen_char[k]) : int'(kbd_char[k]));
          sched(k, t + 2, EV_INC, 0, 0);
          m_free[k] = t + 3;
        end
      end
      m_t[k] = t + 1;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("gen_ready", k, gen_ready[k], e_gr[k]);
        chk("kbd_ready", k, kbd_ready[k], e_kr[k]);
        chk("wr_en", k, wr_en[k], e_wen[k]);
        chk("busy", k, busy[k], e_busy[k]);
        chk("full", k, full[k], e_full[k]);
        chk("char_count", k, char_count[k], e_count[k]);
        if (e_wen[k]) begin
          chk("wr_addr", k, wr_addr[k], e_addr[k]);
          chk("wr_data", k, wr_data[k], e_data[k]);
        end
      end
    end
  end

  // ---------------- observation logs ----------------
  int cycn = 0;
  int n_rdy [2];
  bit last_rdy_gen [2];
  int n_busy0 = 0;
  int w0_addr [$], w0_data [$], c0_addr [$], c0_data [$], w1_time [$];

  task automatic cyc();
    @(negedge clk);
    cycn++;
    for (int k = 0; k < 2; k++) begin
      if (gen_ready[k] || kbd_ready[k]) begin
        n_rdy[k]++;
        last_rdy_gen[k] = gen_ready[k];
      end
    end
    if (busy[0]) n_busy0++;
    if (wr_en[0] && !busy[0]) begin w0_addr.push_back(int'(wr_addr[0])); w0_data.push_back(int'(wr_data[0])); end
    if (wr_en[0] &&  busy[0]) begin c0_addr.push_back(int'(wr_addr[0])); c0_data.push_back(int'(wr_data[0])); end
    if (wr_en[1] && !busy[1]) w1_time.push_back(cycn);
  endtask

  task automatic chk_reset_vals(input string name, input int k);
    chk({name, "_wr_en"}, k, wr_en[k], 0);
    chk({name, "_wr_addr"}, k, wr_addr[k], 0);
    chk({name, "_wr_data"}, k, wr_data[k], 0);
    chk({name, "_count"}, k, char_count[k], 0);
    chk({name, "_full"}, k, full[k], 0);
    chk({name, "_busy"}, k, busy[k], 0);
    chk({name, "_ready"}, k, {gen_ready[k], kbd_ready[k]}, 0);
  endtask

  // ---------------- stimulus ----------------
  bit g_acc [2], k_acc [2];

  task automatic rand_drive(input int k);
    if (gen_ready[k]) g_acc[k] = 1;
    else if (g_acc[k]) begin
      g_acc[k] = 0; gen_valid[k] = 1'($urandom_range(0, 1)); gen_char[k] = 8'($urandom);
    end else if (!gen_valid[k] && $urandom_range(0, 3) == 0) begin
      gen_valid[k] = 1; gen_char[k] = 8'($urandom);
    end
    if (kbd_ready[k]) k_acc[k] = 1;
    else if (k_acc[k]) begin
      k_acc[k] = 0; kbd_valid[k] = 1'($urandom_range(0, 1)); kbd_char[k] = 8'($urandom);
    end else if (!kbd_valid[k] && $urandom_range(0, 3) == 0) begin
      kbd_valid[k] = 1; kbd_char[k] = 8'($urandom);
    end
    if ($urandom_range(0, 29) == 0) execute[k] = ~execute[k];
    clear[k] = ($urandom_range(0, 59) == 0);
    rst_n[k] = ($urandom_range(0, 399) != 0);
  endtask

  initial begin
    int guard, prev;
    rst_n = 2'b00; execute = 2'b00; clear = 2'b00; gen_valid = 2'b00; kbd_valid = 2'b00;
    gen_char[0] = 8'h00; gen_char[1] = 8'h00; kbd_char[0] = 8'h00; kbd_char[1] = 8'h00;
    n_rdy[0] = 0; n_rdy[1] = 0;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk_reset_vals("reset", 0);

    // single source: tick at count 3, ready next, write after
    rst_n[0] = 1; execute[0] = 1; gen_valid[0] = 1; gen_char[0] = 8'h61;
    repeat (4) cyc();
    chk("t1_gen_ready", 0, gen_ready[0], 1);
    cyc();
    chk("t1_wr_en", 0, wr_en[0], 1);
    chk("t1_wr_addr", 0, wr_addr[0], 0);
    chk("t1_wr_data", 0, wr_data[0], 8'h61);
    cyc();
    chk("t1_count", 0, char_count[0], 1);

    // both sources until full
    rst_n[0] = 0; cyc(); rst_n[0] = 1;
    kbd_valid[0] = 1; kbd_char[0] = 8'h41;
    w0_addr.delete(); w0_data.delete();
    guard = 0;
    while (!full[0] && guard < 200) begin cyc(); guard++; end
    chk("t2_full", 0, full[0], 1);
    chk("t2_count", 0, char_count[0], 8);
    chk("t2_nwrites", 0, w0_addr.size(), 8);
    for (int i = 0; i < w0_addr.size() && i < 8; i++) begin
      chk("t2_addr", 0, w0_addr[i], i);
      chk("t2_data", 0, w0_data[i], (i % 2 == 0) ? 8'h61 : 8'h41);
    end
    prev = n_rdy[0];
    repeat (20) cyc();
    chk("t2_no_grant_when_full", 0, n_rdy[0], prev);
    chk("t2_no_write_when_full", 0, w0_addr.size(), 8);

    // clear from full
    c0_addr.delete(); c0_data.delete(); n_busy0 = 0;
    clear[0] = 1; cyc(); clear[0] = 0;
    guard = 0;
    while (busy[0] && guard < 40) begin cyc(); guard++; end
    chk("t3_busy_cycles", 0, n_busy0, 8);
    chk("t3_clear_writes", 0, c0_addr.size(), 8);
    for (int i = 0; i < c0_addr.size() && i < 8; i++) begin
      chk("t3_clear_addr", 0, c0_addr[i], i);
      chk("t3_clear_data", 0, c0_data[i], 8'h20);
    end
    chk("t3_count", 0, char_count[0], 0);
    chk("t3_full", 0, full[0], 0);
    prev = n_rdy[0]; guard = 0;
    while (n_rdy[0] == prev && guard < 40) begin cyc(); guard++; end
    chk("t3_grant_seen", 0, n_rdy[0], prev + 1);
    chk("t3_first_grant_gen", 0, last_rdy_gen[0], 1);

    // now in the grant cycle: drop execute and raise clear together
    execute[0] = 0; clear[0] = 1;
    cyc(); clear[0] = 0;
    chk("t4_write_completes", 0, wr_en[0], 1);
    chk("t4_write_data", 0, wr_data[0], 8'h61);
    chk("t4_not_busy_yet", 0, busy[0], 0);
    cyc();
    chk("t4_idle_wr_en", 0, wr_en[0], 0);
    chk("t4_idle_busy", 0, busy[0], 0);
    cyc();
    chk("t4_clear_starts", 0, busy[0], 1);
    repeat (12) cyc();
    prev = n_rdy[0];
    repeat (30) cyc();
    chk("t4_no_grant_exec_low", 0, n_rdy[0], prev);

    // TICK_DIV=1: a write every three cycles, then reset mid-clear
    rst_n[1] = 1; execute[1] = 1; gen_valid[1] = 1; gen_char[1] = 8'h5a;
    w1_time.delete();
    repeat (40) cyc();
    chk("t5_nwrites", 1, w1_time.size(), 8);
    for (int i = 1; i < w1_time.size(); i++) chk("t5_write_spacing", 1, w1_time[i] - w1_time[i-1], 3);
    chk("t5_full", 1, full[1], 1);
    clear[1] = 1; cyc(); clear[1] = 0;
    guard = 0;
    while (!(busy[1] && wr_addr[1] == 3'd4) && guard < 40) begin cyc(); guard++; end
    chk("t5_reached_addr4", 1, {busy[1], wr_addr[1]}, {1'b1, 3'd4});
    rst_n[1] = 0; gen_valid[1] = 0;
    cyc();
    chk_reset_vals("t5_reset", 1);
    rst_n[1] = 1;
    repeat (12) begin
      cyc();
      chk("t5_no_resume_busy", 1, busy[1], 0);
      chk("t5_no_resume_wr_en", 1, wr_en[1], 0);
    end

    // randomized traffic on both instances
    execute = 2'b11; clear = 2'b00;
    g_acc[0] = 0; g_acc[1] = 0; k_acc[0] = 0; k_acc[1] = 0;
    repeat (3000) begin
      cyc();
      rand_drive(0);
      rand_drive(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
